// File: rtl/if_id_buf.sv
// if_id_buf: fetch-to-decode decoupling FIFO presenting its oldest entry to decode.
// Defining IF_ID_BUF_PERF_EN builds the decode-bubble counter behind bubble_cnt_o.
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef STALL_ID
`define STALL_ID 1
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module if_id_buf #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [`STALL_WIDTH-1:0] stall_i,
    input  logic [31:0]             inst_i,
    input  logic [31:0]             pc_i,
    input  logic                    inst_valid_i,
    output logic                    id_ready_o,
    output logic [31:0]             inst_o,
    output logic [31:0]             pc_o,
    output logic                    inst_valid_o,
    output logic [31:0]             bubble_cnt_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO = (AW + 1)'(0);

    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pc_hold;

    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic          w_stall_id;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_stall;

    // Only one stall bit matters here; the rest are folded away deliberately.
    assign w_stall_id     = stall_i[`STALL_ID];
    assign w_unused_stall = ^stall_i;

    // Ready and valid come from registered count only, so no input reaches them combinationally.
    assign id_ready_o   = (r_count != CNT_FULL);
    assign inst_valid_o = (r_count != CNT_ZERO);
    assign w_push       = inst_valid_i & id_ready_o & ~flush_i;
    assign w_pop        = inst_valid_o & ~w_stall_id & ~flush_i;

    assign inst_o = inst_valid_o ? r_mem_inst[r_rd_ptr] : `INST_NOP;
    assign pc_o   = inst_valid_o ? r_mem_pc[r_rd_ptr]   : r_pc_hold;

    // Next pointer/count; flush wins, pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        if (flush_i) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = CNT_ZERO;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
                2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Occupancy state and the PC shown while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= CNT_ZERO;
            r_pc_hold <= 32'h0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_pop) begin
                r_pc_hold <= r_mem_pc[r_rd_ptr];
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= inst_i;
            r_mem_pc[r_wr_ptr]   <= pc_i;
        end
    end

`ifdef IF_ID_BUF_PERF_EN
    logic [31:0] r_bubble_cnt;

    // Count cycles where decode was ready but the buffer had nothing to offer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 32'h0;
        end else if (!inst_valid_o && !w_stall_id && !flush_i) begin
            r_bubble_cnt <= r_bubble_cnt + 32'h1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: DEPTH=2 and DEPTH=4 instances share stimulus, each checked against its own queue model.
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef STALL_ID
`define STALL_ID 1
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_if_id_buf;
`ifdef IF_ID_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    flush_i;
    logic [`STALL_WIDTH-1:0] stall_i;
    logic [31:0]             inst_i;
    logic [31:0]             pc_i;
    logic                    inst_valid_i;

    logic        o2_ready, o2_valid, o4_ready, o4_valid;
    logic [31:0] o2_inst, o2_pc, o2_bub, o4_inst, o4_pc, o4_bub;

    if_id_buf #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .inst_i(inst_i), .pc_i(pc_i), .inst_valid_i(inst_valid_i),
        .id_ready_o(o2_ready), .inst_o(o2_inst), .pc_o(o2_pc),
        .inst_valid_o(o2_valid), .bubble_cnt_o(o2_bub)
    );

    if_id_buf #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
        .inst_i(inst_i), .pc_i(pc_i), .inst_valid_i(inst_valid_i),
        .id_ready_o(o4_ready), .inst_o(o4_inst), .pc_o(o4_pc),
        .inst_valid_o(o4_valid), .bubble_cnt_o(o4_bub)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: shift-down FIFO per instance, head always at index 0.
    logic [63:0] mq [2][4];
    int          mcnt  [2];
    logic [31:0] mlast [2];
    logic [31:0] mbub  [2];

    typedef struct {
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            mlast[k] = 32'h0;
            mbub[k]  = 32'h0;
        end
    endtask

    task automatic model_step(input logic f, input logic s, input logic v,
                              input logic [31:0] pc, input logic [31:0] inst);
        for (int k = 0; k < 2; k++) begin
            int  d;
            bit  can_push;
            d = (k == 0) ? 2 : 4;
            if (f) begin
                mcnt[k] = 0;
            end else begin
                if (mcnt[k] == 0 && !s) mbub[k] = mbub[k] + 32'h1;
                can_push = v && (mcnt[k] < d);
                if (mcnt[k] > 0 && !s) begin
                    mlast[k] = mq[k][0][31:0];
                    for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
                    mcnt[k]--;
                end
                if (can_push) begin
                    mq[k][mcnt[k]] = {inst, pc};
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int          d;
            logic        a_valid, a_ready;
            logic [31:0] a_inst, a_pc, a_bub;
            logic [31:0] e_inst, e_pc;
            d       = (k == 0) ? 2 : 4;
            a_valid = (k == 0) ? o2_valid : o4_valid;
            a_ready = (k == 0) ? o2_ready : o4_ready;
            a_inst  = (k == 0) ? o2_inst  : o4_inst;
            a_pc    = (k == 0) ? o2_pc    : o4_pc;
            a_bub   = (k == 0) ? o2_bub   : o4_bub;
            e_inst  = (mcnt[k] > 0) ? mq[k][0][63:32] : `INST_NOP;
            e_pc    = (mcnt[k] > 0) ? mq[k][0][31:0]  : mlast[k];
            chk($sformatf("d%0d inst_valid_o", d), {31'h0, a_valid}, {31'h0, (mcnt[k] > 0)});
            chk($sformatf("d%0d id_ready_o", d), {31'h0, a_ready}, {31'h0, (mcnt[k] != d)});
            chk($sformatf("d%0d inst_o", d), a_inst, e_inst);
            chk($sformatf("d%0d pc_o", d), a_pc, e_pc);
            chk($sformatf("d%0d bubble_cnt_o", d), a_bub, PERF ? mbub[k] : 32'h0);
        end
    endtask

    task automatic step(input logic f, input logic s, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst);
        flush_i      = f;
        stall_i      = `STALL_WIDTH'($urandom);
        stall_i[`STALL_ID] = s;
        inst_valid_i = v;
        pc_i         = pc;
        inst_i       = inst;
        model_step(f, s, v, pc, inst);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        stall_i      = '0;
        inst_valid_i = 1'b0;
        inst_i       = 32'h0;
        pc_i         = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc_ctr;

        // Directed DEPTH=2 expectations: outputs seen the cycle after each vector.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b1, 32'h000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h004, 1'b1, 32'h004, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h008, 1'b1, 32'h008, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h008, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'h104, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h104, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 32'h204, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h208, 1'b1, 32'h204, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h20C, 1'b0, 32'h200, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h200, 1'b1};

        do_reset();
        chk("reset inst_valid_o", {31'h0, o2_valid}, 32'h0);
        chk("reset id_ready_o", {31'h0, o2_ready}, 32'h1);
        chk("reset inst_o", o2_inst, `INST_NOP);
        chk("reset pc_o", o2_pc, 32'h0);
        chk("reset bubble_cnt_o", o2_bub, 32'h0);
        check_all();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].pc,
                 vecs[i].pc ^ 32'hDEAD_0000);
            chk($sformatf("vec%0d inst_valid_o", i), {31'h0, o2_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d pc_o", i), o2_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d id_ready_o", i), {31'h0, o2_ready}, {31'h0, vecs[i].exp_ready});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d inst_o", i), o2_inst, vecs[i].exp_pc ^ 32'hDEAD_0000);
            end else begin
                chk($sformatf("vec%0d inst_o", i), o2_inst, `INST_NOP);
            end
        end

        // Bubble counter: 5 idle ready cycles, then 3 stalled idle cycles.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("perf d2 bubbles", o2_bub, PERF ? 32'd5 : 32'd0);
        chk("perf d4 bubbles", o4_bub, PERF ? 32'd5 : 32'd0);

        // Asynchronous reset in the middle of a cycle with entries held.
        step(1'b0, 1'b1, 1'b1, 32'h300, 32'h1111_0000);
        step(1'b0, 1'b1, 1'b1, 32'h304, 32'h1111_0004);
        step(1'b0, 1'b0, 1'b1, 32'h308, 32'h1111_0008);
        rst_n = 1'b0;
        #1;
        chk("async rst d2 valid", {31'h0, o2_valid}, 32'h0);
        chk("async rst d2 ready", {31'h0, o2_ready}, 32'h1);
        chk("async rst d2 inst", o2_inst, `INST_NOP);
        chk("async rst d2 pc", o2_pc, 32'h0);
        chk("async rst d4 valid", {31'h0, o4_valid}, 32'h0);
        chk("async rst d4 pc", o4_pc, 32'h0);
        chk("async rst d4 bub", o4_bub, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Wrap-around: 10 pushes with random stall, then drain.
        pc_ctr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, pc_ctr, $urandom);
            pc_ctr = pc_ctr + 32'h4;
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), pc_ctr, $urandom);
            pc_ctr = pc_ctr + 32'h4;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
